qc_ldpc_encode: RTL and testbench

- Systematic QC-LDPC encoder, the transmit-side counterpart of the NMS decoder; same code: N=9216, Z=256, NB=36 block columns, MB=9 block rows, rate 3/4.
- Accepts 27 Z-bit info blocks one per beat and accumulates rotated copies into 9 parity rows. Back-substitutes the dual-diagonal parity part, then presents a 9216-bit codeword in the decoder's buffer_in layout.

---
 rtl/qc_ldpc_encode_pkg.sv | 41 ++++
 rtl/qc_ldpc_encode_if.sv | 40 ++++
 rtl/qc_ldpc_encode_shift_rom.sv | 35 +++
 rtl/qc_ldpc_encode.sv | 159 +++++++++++++++
 tb/tb_qc_ldpc_encode.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qc_ldpc_encode_pkg.sv
// Shared constants, FSM encoding and rotate helper for the QC-LDPC encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Code: N=9216, Z=256, 36 block columns, 9 block rows, 27 info blocks (rate 3/4).
package qc_ldpc_encode_pkg;

  localparam int Z   = 256;      // circulant size
  localparam int NB  = 36;       // block columns
  localparam int MB  = 9;        // block rows / parity blocks
  localparam int SW  = 8;        // shift field width, 2^SW >= Z
  localparam int K_B = NB - MB;  // info blocks
  localparam int N   = NB * Z;   // codeword bits

  localparam int CW = 6;         // shared counter: beats 0..26, rows 0..8, stream blocks 0..35
  localparam int JW = 5;         // info column index width
  localparam int RW = 4;         // block row index width

  localparam logic [CW-1:0] LAST_BEAT = CW'(K_B - 1);
  localparam logic [CW-1:0] LAST_ROW  = CW'(MB - 1);
  localparam logic [CW-1:0] LAST_BLK  = CW'(NB - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PARITY = 3'd2,
    ST_DONE   = 3'd3,
    ST_STREAM = 3'd4
  } enc_state_e;

  // One H_b info-part entry: valid=0 means an all-zero block.
  typedef struct packed {
    logic          valid;
    logic [SW-1:0] shift;
  } hb_ent_t;

  // rot(x,s): out[k] = x[(k+s) mod Z]; the doubled vector makes the wrap free.
  function automatic logic [Z-1:0] rot(input logic [Z-1:0] x, input logic [SW-1:0] s);
    return Z'({x, x} >> s);
  endfunction

endpackage

// File: rtl/qc_ldpc_encode_if.sv
// Bus bundle between the encoder and its driver (info beats, status, codeword).
// Latency: n/a (wires only).
// Backpressure: din_valid/din_ready; with QC_LDPC_ENC_STREAM_OUT_EN also dout_valid/dout_ready.
// master = block driving info beats, slave = encoder.
interface qc_ldpc_encode_if;
  import qc_ldpc_encode_pkg::*;

  logic         start_enc;
  logic [Z-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         busy;
  logic [N-1:0] code_out;
  logic         finish_enc;

`ifdef QC_LDPC_ENC_STREAM_OUT_EN
  logic [Z-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;

  modport master (
    output start_enc, din, din_valid, dout_ready,
    input  din_ready, busy, code_out, finish_enc, dout, dout_valid
  );
  modport slave (
    input  start_enc, din, din_valid, dout_ready,
    output din_ready, busy, code_out, finish_enc, dout, dout_valid
  );
`else
  modport master (
    output start_enc, din, din_valid,
    input  din_ready, busy, code_out, finish_enc
  );
  modport slave (
    input  start_enc, din, din_valid,
    output din_ready, busy, code_out, finish_enc
  );
`endif

endinterface

// File: rtl/qc_ldpc_encode_shift_rom.sv
// H_b info-part table lookup: the MB {valid, shift} entries of info column j.
// Latency: combinational.
// Backpressure: none.
// Ports: j_i column index 0..26 (higher values return all-invalid); ent_o[i] entry of row i.
module qc_enc_shift_rom
  import qc_ldpc_encode_pkg::*;
(
  input  logic [JW-1:0]    j_i,
  output hb_ent_t [MB-1:0] ent_o
);

  // -1 marks a zero block; this table is shared with the decoder's H generation.
  localparam int HB [MB][K_B] = '{
    '{ 12,  -1, 200,  47,  -1,  91, 130,  -1,   5, 222,  -1,  64,  17,  -1, 189, 250,  -1,  33,  -1, 108,  76,  -1, 141,   2,  -1, 199,  55},
    '{ -1,  83,  19,  -1, 240,  -1,  71, 155,  -1,  38, 117,  -1, 201,   9,  -1,  -1, 176,  -1, 220,  44,  -1,  93,  -1, 128,  61,  -1, 254},
    '{101,  27,  -1, 163,  58,  -1,  -1, 212,  89,  -1,  14, 180,  -1, 245,  36,  -1,  -1, 119,  73,  -1, 206,  -1,   8,  -1, 150,  97,  -1},
    '{ -1,  -1,  66,   1,  -1, 233,  40,  -1, 172,  11,  -1,  -1,  85, 160,  -1,  29, 214,  -1,  -1, 137,  52, 247,  -1,  -1,  18,  -1, 121},
    '{250, 143,  -1,  -1,  99,  20,  -1,  77,  -1,  -1, 198,  35,  -1,  -1, 111,  68,  -1, 183,   6,  -1,  -1, 159, 227,  42,  -1,  87,  -1},
    '{ -1,   0, 125, 208,  -1,  -1, 255,  -1,  31, 146,  -1,  92, 237,  -1,  -1, 174,  50,  -1, 113,  24,  -1,  -1,  60, 191,  -1, 139,   7},
    '{ 45,  -1,  -1, 118, 187,   3,  -1, 132,  -1,  70, 215,  -1,  -1,  81, 166,  -1,  96, 243,  -1,  -1,  10, 127,  -1,  57, 230,  -1,  -1},
    '{168, 212,  74,  -1,  -1,  48, 153,  -1, 105,  -1,  26, 241, 134,  -1,  79,  -1,  -1,  15, 197,  62,  -1,  -1, 184,  -1,  39, 226, 100},
    '{ -1,  59,  -1,  13, 176,  -1,  88, 218,  -1, 194,  -1, 123,  -1,  37,  -1, 252, 145,  67,  -1, 209, 115,  30,  -1, 171,  -1,   4,  82}
  };

  always_comb begin
    ent_o = '0;
    for (int i = 0; i < MB; i++) begin
      if ((j_i < JW'(K_B)) && (HB[i][j_i] >= 0)) begin
        ent_o[i].valid = 1'b1;
        ent_o[i].shift = SW'(HB[i][j_i]);
      end
    end
  end

endmodule

// File: rtl/qc_ldpc_encode.sv
// Systematic QC-LDPC encoder: accumulates 27 rotated info blocks into 9 rows, back-substitutes parity.
// Latency: start_enc at cycle 0, no stalls -> finish_enc at cycle 37; 38 cycles per codeword back-to-back.
// Backpressure: din_ready only in LOAD, din_valid gaps stall; optional stream output waits on dout_ready.
// Ports: clk, rst (sync, active-high); bus (slave) carries start_enc, din/din_valid/din_ready, busy,
//        code_out (block j at [j*Z +: Z]), finish_enc; with QC_LDPC_ENC_STREAM_OUT_EN also dout/dout_valid/dout_ready.
module qc_ldpc_encode
  import qc_ldpc_encode_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  qc_ldpc_encode_if.slave bus
);

  enc_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [MB-1:0][Z-1:0]  acc_q;
  logic [K_B-1:0][Z-1:0] info_q;
  logic [N-1:0]          code_q;

  logic                  acc_clr, beat_xfer, par_step, cw_load;
  logic                  din_rdy, fin_pulse;
  hb_ent_t [MB-1:0]      ent;
  logic [MB-1:0][Z-1:0]  rot_dat;
  logic [RW-1:0]         row;
  logic [Z-1:0]          par_row;
  logic [MB-1:0][Z-1:0]  par_final;

  // The beat counter doubles as the info column index while loading.
  qc_enc_shift_rom u_rom (
    .j_i   (cnt_q[JW-1:0]),
    .ent_o (ent)
  );

  for (genvar gi = 0; gi < MB; gi++) begin : g_rot
    assign rot_dat[gi] = ent[gi].valid ? rot(bus.din, ent[gi].shift) : '0;
  end

  // Dual-diagonal back-substitution: row i becomes acc_i ^ p_{i-1}; row i-1 already holds p_{i-1}.
  assign row = cnt_q[RW-1:0];

  always_comb begin
    par_row = acc_q[row];
    if (row != '0) begin
      par_row = par_row ^ acc_q[row - RW'(1)];
    end
    // On the last row the final parity is not yet registered, so splice it into the codeword load.
    par_final         = acc_q;
    par_final[MB-1]   = par_row;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_clr   = 1'b0;
    beat_xfer = 1'b0;
    par_step  = 1'b0;
    cw_load   = 1'b0;
    din_rdy   = 1'b0;
    fin_pulse = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_enc) begin
          acc_clr = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        din_rdy = 1'b1;
        if (bus.din_valid) begin
          beat_xfer = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_PARITY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_PARITY: begin
        par_step = 1'b1;
        if (cnt_q == LAST_ROW) begin
          cw_load = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        // code_q was loaded on the edge into DONE, so the pulse lines up with the new codeword.
        fin_pulse = 1'b1;
`ifdef QC_LDPC_ENC_STREAM_OUT_EN
        cnt_d   = '0;
        state_d = ST_STREAM;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef QC_LDPC_ENC_STREAM_OUT_EN
      ST_STREAM: begin
        if (bus.dout_ready) begin
          if (cnt_q == LAST_BLK) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      info_q <= '0;
      code_q <= '0;
    end else begin
      if (acc_clr) begin
        acc_q <= '0;
      end else if (beat_xfer) begin
        acc_q                 <= acc_q ^ rot_dat;
        info_q[cnt_q[JW-1:0]] <= bus.din;
      end else if (par_step) begin
        acc_q[row] <= par_row;
      end
      if (cw_load) begin
        code_q <= {par_final, info_q};
      end
    end
  end

  assign bus.din_ready  = din_rdy;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.finish_enc = fin_pulse;
  assign bus.code_out   = code_q;

`ifdef QC_LDPC_ENC_STREAM_OUT_EN
  assign bus.dout_valid = (state_q == ST_STREAM);
  assign bus.dout       = code_q[int'(cnt_q) * Z +: Z];
`endif

endmodule

// File: tb/tb_qc_ldpc_encode.sv
// Directed bench for qc_ldpc_encode: reset, zero/single-one/random codewords, ignored starts,
// back-to-back spacing, mid-LOAD abort; stream output drained when QC_LDPC_ENC_STREAM_OUT_EN is set.
// Expected codewords come from a bench-side copy of H_b and a bit-loop rotate model.
module tb_qc_ldpc_encode;
  import qc_ldpc_encode_pkg::*;

  logic clk;
  logic rst;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  int   rdy_cnt = 0;
  int   fin_cnt = 0;

  qc_ldpc_encode_if bus ();

  qc_ldpc_encode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam int HB_REF [MB][K_B] = '{
    '{ 12,  -1, 200,  47,  -1,  91, 130,  -1,   5, 222,  -1,  64,  17,  -1, 189, 250,  -1,  33,  -1, 108,  76,  -1, 141,   2,  -1, 199,  55},
    '{ -1,  83,  19,  -1, 240,  -1,  71, 155,  -1,  38, 117,  -1, 201,   9,  -1,  -1, 176,  -1, 220,  44,  -1,  93,  -1, 128,  61,  -1, 254},
    '{101,  27,  -1, 163,  58,  -1,  -1, 212,  89,  -1,  14, 180,  -1, 245,  36,  -1,  -1, 119,  73,  -1, 206,  -1,   8,  -1, 150,  97,  -1},
    '{ -1,  -1,  66,   1,  -1, 233,  40,  -1, 172,  11,  -1,  -1,  85, 160,  -1,  29, 214,  -1,  -1, 137,  52, 247,  -1,  -1,  18,  -1, 121},
    '{250, 143,  -1,  -1,  99,  20,  -1,  77,  -1,  -1, 198,  35,  -1,  -1, 111,  68,  -1, 183,   6,  -1,  -1, 159, 227,  42,  -1,  87,  -1},
    '{ -1,   0, 125, 208,  -1,  -1, 255,  -1,  31, 146,  -1,  92, 237,  -1,  -1, 174,  50,  -1, 113,  24,  -1,  -1,  60, 191,  -1, 139,   7},
    '{ 45,  -1,  -1, 118, 187,   3,  -1, 132,  -1,  70, 215,  -1,  -1,  81, 166,  -1,  96, 243,  -1,  -1,  10, 127,  -1,  57, 230,  -1,  -1},
    '{168, 212,  74,  -1,  -1,  48, 153,  -1, 105,  -1,  26, 241, 134,  -1,  79,  -1,  -1,  15, 197,  62,  -1,  -1, 184,  -1,  39, 226, 100},
    '{ -1,  59,  -1,  13, 176,  -1,  88, 218,  -1, 194,  -1, 123,  -1,  37,  -1, 252, 145,  67,  -1, 209, 115,  30,  -1, 171,  -1,   4,  82}
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.din_ready === 1'b1)  rdy_cnt <= rdy_cnt + 1;
    if (bus.finish_enc === 1'b1) fin_cnt <= fin_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [Z-1:0] obs, input logic [Z-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [Z-1:0] brot(input logic [Z-1:0] x, input int s);
    logic [Z-1:0] r;
    for (int k = 0; k < Z; k++) r[k] = x[(k + s) % Z];
    return r;
  endfunction

  function automatic logic [N-1:0] golden(input logic [K_B-1:0][Z-1:0] info);
    logic [MB-1:0][Z-1:0] acc;
    acc = '0;
    for (int i = 0; i < MB; i++)
      for (int j = 0; j < K_B; j++)
        if (HB_REF[i][j] >= 0) acc[i] = acc[i] ^ brot(info[j], HB_REF[i][j]);
    for (int i = 1; i < MB; i++) acc[i] = acc[i] ^ acc[i-1];
    return {acc, info};
  endfunction

  task automatic cmp_cw(input string pfx, input logic [N-1:0] obs, input logic [N-1:0] exp);
    for (int b = 0; b < NB; b++)
      chk($sformatf("%s blk%0d", pfx, b), obs[b*Z +: Z], exp[b*Z +: Z]);
  endtask

  // Every row of H times the codeword must vanish.
  task automatic syn_chk(input string pfx, input logic [N-1:0] c);
    logic [Z-1:0] s;
    for (int i = 0; i < MB; i++) begin
      s = c[(K_B + i) * Z +: Z];
      if (i > 0) s = s ^ c[(K_B + i - 1) * Z +: Z];
      for (int j = 0; j < K_B; j++)
        if (HB_REF[i][j] >= 0) s = s ^ brot(c[j*Z +: Z], HB_REF[i][j]);
      chk($sformatf("%s syndrome row%0d", pfx, i), s, '0);
    end
  endtask

  task automatic rand_info(output logic [K_B-1:0][Z-1:0] info);
    for (int j = 0; j < K_B; j++)
      for (int w = 0; w < Z / 32; w++) info[j][w*32 +: 32] = $urandom;
  endtask

  // One idle cycle, start pulse, beats with optional gaps/extra start pulses, wait for finish_enc.
  task automatic encode(input logic [K_B-1:0][Z-1:0] info, input int gap_pct, input bit poke,
                        output logic [N-1:0] cw, output int lat, output int fcyc);
    int  j, n, t0;
    bit  v, xfer;
    tick;
    bus.start_enc = 1'b1;
    t0 = cyc;
    tick;
    bus.start_enc = 1'b0;
    j = 0;
    n = 0;
    while (j < K_B && n < 1000) begin
      v = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      bus.din_valid = v;
      bus.din       = info[j];
      if (poke && j == 5) bus.start_enc = 1'b1;
      xfer = v && (bus.din_ready === 1'b1);
      tick;
      n++;
      bus.start_enc = 1'b0;
      if (xfer) j++;
    end
    bus.din_valid = 1'b0;
    chk_i("beats accepted", j, K_B);
    fcyc = -1;
    for (int k = 0; k < 100 && fcyc < 0; k++) begin
      if (bus.finish_enc === 1'b1) begin
        fcyc = cyc;
      end else begin
        if (poke && k == 3) bus.start_enc = 1'b1;
        tick;
        bus.start_enc = 1'b0;
      end
    end
    chk_i("finish_enc seen", int'(fcyc >= 0), 1);
    lat = fcyc - t0;
    cw  = bus.code_out;
  endtask

`ifdef QC_LDPC_ENC_STREAM_OUT_EN
  task automatic drain(input logic [N-1:0] cw);
    int k, n;
    bit rdy;
    k = 0;
    n = 0;
    rdy = 1'b1;
    tick;
    while (k < NB && n < 400) begin
      bus.dout_ready = rdy;
      if (bus.dout_valid === 1'b1 && rdy) begin
        chk($sformatf("stream blk%0d", k), bus.dout, cw[k*Z +: Z]);
        k++;
      end
      tick;
      n++;
      rdy = ~rdy;
    end
    bus.dout_ready = 1'b0;
    chk_i("stream blocks", k, NB);
    chk_i("stream busy drop", int'(bus.busy), 0);
  endtask
`endif

  task automatic after_done(input logic [N-1:0] cw);
`ifdef QC_LDPC_ENC_STREAM_OUT_EN
    drain(cw);
`else
    tick;
    chk_i("finish one cycle", int'(bus.finish_enc), 0);
    chk_i("idle busy", int'(bus.busy), 0);
    chk_i("code held", int'(bus.code_out === cw), 1);
`endif
  endtask

  initial begin
    logic [K_B-1:0][Z-1:0] info, info_b;
    logic [N-1:0]          cw, cw_b;
    logic [Z-1:0]          pe;
    int                    lat, fa, fb, r0, f0;

    rst           = 1'b1;
    bus.start_enc = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
`ifdef QC_LDPC_ENC_STREAM_OUT_EN
    bus.dout_ready = 1'b0;
`endif
    repeat (3) tick;
    chk_i("reset busy", int'(bus.busy), 0);
    chk_i("reset din_ready", int'(bus.din_ready), 0);
    chk_i("reset finish", int'(bus.finish_enc), 0);
    cmp_cw("reset code", bus.code_out, '0);
    rst = 1'b0;

    // All-zero info, no stalls.
    info = '0;
    r0   = rdy_cnt;
    f0   = fin_cnt;
    encode(info, 0, 1'b0, cw, lat, fa);
    chk_i("zero latency", lat, 37);
    cmp_cw("zero code", cw, '0);
    chk_i("zero din_ready cycles", rdy_cnt - r0, 27);
    after_done(cw);
    chk_i("zero finish pulses", fin_cnt - f0, 1);

    // Single one at block 0 bit 0: column 0 hits rows 0,2,4,6,7 with shifts 12,101,250,45,168,
    // so rot(e0,s) sets bit Z-s: 244,155,6,211,88, accumulated down the parity chain.
    info       = '0;
    info[0][0] = 1'b1;
    encode(info, 0, 1'b0, cw, lat, fa);
    pe = '0;
    pe[0] = 1'b1;
    chk("one info blk0", cw[0 +: Z], pe);
    pe = '0;
    pe[244] = 1'b1;
    chk("one p0", cw[27*Z +: Z], pe);
    chk("one p1", cw[28*Z +: Z], pe);
    pe[155] = 1'b1;
    chk("one p2", cw[29*Z +: Z], pe);
    chk("one p3", cw[30*Z +: Z], pe);
    pe[6] = 1'b1;
    chk("one p4", cw[31*Z +: Z], pe);
    chk("one p5", cw[32*Z +: Z], pe);
    pe[211] = 1'b1;
    chk("one p6", cw[33*Z +: Z], pe);
    pe[88] = 1'b1;
    chk("one p7", cw[34*Z +: Z], pe);
    chk("one p8", cw[35*Z +: Z], pe);
    cmp_cw("one model", cw, golden(info));
    after_done(cw);

    // Random info, 40% valid gaps, stray start pulses in LOAD and PARITY.
    rand_info(info);
    encode(info, 40, 1'b1, cw, lat, fa);
    cmp_cw("gap model", cw, golden(info));
    syn_chk("gap", cw);
    after_done(cw);

    // Two codewords back-to-back.
    rand_info(info);
    rand_info(info_b);
    encode(info, 0, 1'b0, cw, lat, fa);
`ifdef QC_LDPC_ENC_STREAM_OUT_EN
    after_done(cw);
`endif
    encode(info_b, 0, 1'b0, cw_b, lat, fb);
`ifndef QC_LDPC_ENC_STREAM_OUT_EN
    chk_i("back-to-back spacing", fb - fa, 38);
`endif
    cmp_cw("b2b first", cw, golden(info));
    cmp_cw("b2b second", cw_b, golden(info_b));
    after_done(cw_b);

    // Reset while beat 13 is on the bus.
    rand_info(info);
    tick;
    f0 = fin_cnt;
    bus.start_enc = 1'b1;
    tick;
    bus.start_enc = 1'b0;
    for (int k = 0; k < 13; k++) begin
      bus.din_valid = 1'b1;
      bus.din       = info[k];
      tick;
    end
    bus.din = info[13];
    rst     = 1'b1;
    tick;
    rst           = 1'b0;
    bus.din_valid = 1'b0;
    chk_i("abort busy", int'(bus.busy), 0);
    chk_i("abort finish", int'(bus.finish_enc), 0);
    chk_i("abort din_ready", int'(bus.din_ready), 0);
    cmp_cw("abort code", bus.code_out, '0);
    repeat (45) tick;
    chk_i("abort no finish", fin_cnt - f0, 0);
    encode(info, 0, 1'b0, cw, lat, fa);
    chk_i("post-abort latency", lat, 37);
    cmp_cw("post-abort model", cw, golden(info));
    after_done(cw);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
